// File: rtl/pipelined_addsub_pkg.sv
// Shared helpers for pipelined arithmetic blocks: slice sizing and
// parameter legality, so every sliced datapath derives them the same way.
package pipelined_addsub_pkg;

    // Width of one pipeline slice; guards against a zero stage count so the
    // legality check below can still elaborate and report the problem.
    function automatic int sliceWidth(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

    // A sliced datapath needs at least one stage and an exact split of the
    // word into equal slices.
    function automatic bit paramsLegal(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end
        return (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_rca_slice.sv
// Combinational ripple-carry adder for one pipeline slice. Besides the
// carry out it exposes the carry into the slice MSB, which the top slice
// needs for signed overflow detection.
module rca_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < W; i++) begin : gBit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign co       = carry[W];
    assign c_msb_in = carry[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES registered ripple-carry slices.
// Each stage adds one slice, passes its carry up, carries the untouched
// upper operand bits forward and accumulates the finished lower sum bits,
// so a whole result emerges from the last stage at once. A single global
// enable freezes the entire pipeline while the consumer stalls.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = sliceWidth(WIDTH, STAGES);

    if (!paramsLegal(WIDTH, STAGES)) begin : gBadParams
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    logic              en;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];

    // Valid bits shift one stage per enabled cycle; bubbles travel too.
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    // Valid chain register: cleared on reset, frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int REM_IN = WIDTH - k * SLICE;

        logic [REM_IN-1:0]        opA;
        logic [REM_IN-1:0]        opB;
        logic                     carryIn;
        logic                     carryOut;
        logic                     unusedCMsb;
        logic [SLICE-1:0]         sliceSum;
        logic [(k+1)*SLICE-1:0]   sum_d;
        logic [(k+1)*SLICE-1:0]   sum_q;

        if (k == 0) begin : gHead
            assign opA     = A;
            assign opB     = B ^ {WIDTH{sub}};
            assign carryIn = sub | cin;
            assign sum_d   = sliceSum;
        end else begin : gBody
            assign opA     = gStage[k-1].gSkew.opA_q;
            assign opB     = gStage[k-1].gSkew.opB_q;
            assign carryIn = gStage[k-1].gSkew.carry_q;
            assign sum_d   = {sliceSum, gStage[k-1].sum_q};
        end

        rca_slice #(
            .W(SLICE)
        ) uSlice (
            .a        (opA[SLICE-1:0]),
            .b        (opB[SLICE-1:0]),
            .ci       (carryIn),
            .s        (sliceSum),
            .co       (carryOut),
            .c_msb_in (unusedCMsb)
        );

        // Completed low sum slices accumulate so the result leaves in one piece.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
            end else if (en) begin
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : gSkew
            logic [REM_IN-SLICE-1:0] opA_q;
            logic [REM_IN-SLICE-1:0] opB_q;
            logic                    carry_q;

            // Upper operand bits and the slice carry travel with the beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opA_q   <= '0;
                    opB_q   <= '0;
                    carry_q <= 1'b0;
                end else if (en) begin
                    opA_q   <= opA[REM_IN-1:SLICE];
                    opB_q   <= opB[REM_IN-1:SLICE];
                    carry_q <= carryOut;
                end
            end
        end else begin : gTail
            logic cout_q;
            logic ovf_q;

            // Top slice registers the final carry and the signed overflow flag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (en) begin
                    cout_q <= carryOut;
                    ovf_q  <= carryOut ^ unusedCMsb;
                end
            end
        end
    end

    assign sum  = gStage[STAGES-1].sum_q;
    assign cout = gStage[STAGES-1].gTail.cout_q;
    assign ovf  = gStage[STAGES-1].gTail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub at WIDTH=16, STAGES=4: directed beats from the
// test plan plus randomized traffic, checked against an arithmetic model
// through an in-order queue of expected results.
module tb_pipelined_addsub;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t expQ[$];
    int   popSteps[$];
    int   total = 0;
    int   bad = 0;
    int   stepCount = 0;
    int   lastPopStep = 0;
    int   accStep = 0;
    logic [W+2:0] snap;

    pipelined_addsub #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Behavioural reference: unsigned sum for result and carry, signed sum
    // range check for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t         m;
        logic [W-1:0] bop;
        int           c0;
        int           ru;
        int           rs;
        bop = sb ? ~b : b;
        c0  = sb ? 1 : int'(ci);
        ru  = int'({16'd0, a}) + int'({16'd0, bop}) + c0;
        rs  = int'($signed(a)) + int'($signed(bop)) + c0;
        m.s = ru[W-1:0];
        m.c = ru[W];
        m.o = (rs > 32767) || (rs < -32768);
        return m;
    endfunction

    function automatic exp_t mkExp(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // A result transfer happens this cycle: it must match the oldest expectation.
    task automatic checkOutput();
        exp_t e;
        if (out_valid && out_ready) begin
            total++;
            assert (expQ.size() != 0) else begin
                bad++;
                $error("[TB] FAIL spurious_result observed sum=%0d expected no beat", sum);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                total--;
                checkEq("result{sum,cout,ovf}", {13'd0, sum, cout, ovf}, {13'd0, e.s, e.c, e.o});
                lastPopStep = stepCount;
                popSteps.push_back(stepCount);
            end
        end
    endtask

    // One cycle: drive at the falling edge, check the transfer that the next
    // rising edge will perform, and queue the accepted operand beat.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb, input logic ordy,
                                 input bit useExp, input exp_t e);
        @(negedge clk);
        stepCount++;
        in_valid  = v;
        A         = a;
        B         = b;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        checkOutput();
        if (v && in_ready) begin
            expQ.push_back(useExp ? e : model(a, b, ci, sb));
            accStep = stepCount;
        end
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        applyStimulus(1'b1, a, b, ci, sb, 1'b1, 1'b0, '0);
    endtask

    task automatic beatExp(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic sb, input exp_t e);
        applyStimulus(1'b1, a, b, ci, sb, 1'b1, 1'b1, e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        checkEq({tag, "_drained"}, expQ.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #12;
        checkEq("reset_out_valid", {31'd0, out_valid}, 0);
        checkEq("reset_sum", {16'd0, sum}, 0);
        checkEq("reset_cout", {31'd0, cout}, 0);
        checkEq("reset_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkEq("reset_in_ready", {31'd0, in_ready}, 1);

        $display("[TB] add with carry out");
        beatExp(16'd65000, 16'd65340, 1'b0, 1'b0, mkExp(16'd64804, 1'b1, 1'b0));
        drain("add");
        checkEq("add_latency", lastPopStep - accStep, S);

        $display("[TB] subtract");
        beatExp(16'd1005, 16'd69, 1'b1, 1'b1, mkExp(16'd936, 1'b1, 1'b0));
        beatExp(16'd50, 16'd10024, 1'b0, 1'b1, mkExp(16'd55562, 1'b0, 1'b0));
        drain("sub");

        $display("[TB] signed overflow");
        beatExp(16'h7FFF, 16'd1, 1'b0, 1'b0, mkExp(16'h8000, 1'b0, 1'b1));
        beatExp(16'h8000, 16'd1, 1'b0, 1'b1, mkExp(16'h7FFF, 1'b1, 1'b1));
        drain("ovf");

        $display("[TB] streaming");
        popSteps.delete();
        beatExp(16'd58135, 16'd3592, 1'b0, 1'b0, mkExp(16'd61727, 1'b0, 1'b0));
        checkEq("stream_in_ready0", {31'd0, in_ready}, 1);
        beatExp(16'd15124, 16'd5383, 1'b1, 1'b0, mkExp(16'd20508, 1'b0, 1'b0));
        checkEq("stream_in_ready1", {31'd0, in_ready}, 1);
        beat(16'd1000, 16'd2000, 1'b0, 1'b1);
        beat(16'd40000, 16'd30000, 1'b1, 1'b0);
        beat(16'd12345, 16'd54321, 1'b0, 1'b1);
        beat(16'd32767, 16'd32767, 1'b0, 1'b0);
        checkEq("stream_in_ready5", {31'd0, in_ready}, 1);
        drain("stream");
        checkEq("stream_count", popSteps.size(), 6);
        if (popSteps.size() == 6) begin
            checkEq("stream_back_to_back", popSteps[5] - popSteps[0], 5);
        end

        $display("[TB] backpressure");
        beat(16'd111, 16'd222, 1'b0, 1'b0);
        beat(16'd3000, 16'd4000, 1'b1, 1'b1);
        beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        beat(16'd9, 16'd10, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd500, 16'd600, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkEq("stall_out_valid", {31'd0, out_valid}, 1);
        checkEq("stall_in_ready0", {31'd0, in_ready}, 0);
        snap = {sum, cout, ovf, out_valid};
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1'b1, 16'd500, 16'd600, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            checkEq("stall_hold", {13'd0, sum, cout, ovf, out_valid}, {13'd0, snap});
            checkEq("stall_in_ready", {31'd0, in_ready}, 0);
        end
        applyStimulus(1'b1, 16'd500, 16'd600, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkEq("release_in_ready", {31'd0, in_ready}, 1);
        drain("backpressure");

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 3) != 0), 1'b0, '0);
        end
        drain("random");

        $display("[TB] reset mid-stream");
        beat(16'd1, 16'd2, 1'b0, 1'b0);
        beat(16'd3, 16'd4, 1'b0, 1'b0);
        beat(16'd5, 16'd6, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkEq("async_rst_out_valid", {31'd0, out_valid}, 0);
        checkEq("async_rst_sum", {16'd0, sum}, 0);
        checkEq("async_rst_cout_ovf", {30'd0, cout, ovf}, 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkEq("post_rst_in_ready", {31'd0, in_ready}, 1);
        beatExp(16'd50, 16'd10024, 1'b0, 1'b0, mkExp(16'd10074, 1'b0, 1'b0));
        drain("post_reset");
        checkEq("post_reset_latency", lastPopStep - accStep, S);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
